// File: rtl/ddr_cmd_sequencer.sv
// DDR command sequencer: walks one request through ACT/CAS/data/PRE timing
// and hands single-cycle strobes to the burst/data stage.
module ddr_cmd_sequencer #(
    parameter int TRCD = 16,
    parameter int TWR  = 12,
    parameter int TRTP = 6,
    parameter int TRP  = 16
) (
    input  logic       clock_t,
    input  logic       reset_n,
    input  logic       init_done,
    input  logic       req_valid,
    input  logic [1:0] req_rw,
    output logic       req_ready,
    input  logic [5:0] rd_delay,
    input  logic [5:0] wr_delay,
    input  logic [3:0] bl,
    output logic       act_rdy,
    output logic       cas_rdy,
    output logic       rw_rdy,
    output logic       pre_rdy,
    output logic       data_active,
    output logic       cmd_err,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ACT   = 4'd1,
        RCD   = 4'd2,
        CAS   = 4'd3,
        LAT   = 4'd4,
        BURST = 4'd5,
        RECOV = 4'd6,
        PRE   = 4'd7,
        RP    = 4'd8
    } state_t;

    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;
    localparam logic [7:0] TRCD_L = TRCD[7:0];
    localparam logic [7:0] TWR_L  = TWR[7:0];
    localparam logic [7:0] TRTP_L = TRTP[7:0];
    localparam logic [7:0] TRP_L  = TRP[7:0];

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [1:0]  rw_r;
    logic [5:0]  dly_r;
    logic [3:0]  bl_r;
    logic        accept_s, rw_ok_s, err_s;
    logic [7:0]  dly_eff_s, beats_s, recov_s;
    logic        act_rdy_r, cas_rdy_r, rw_rdy_r, pre_rdy_r;
    logic        data_active_r, cmd_err_r, busy_r;

    assign req_ready = (state_r == IDLE) && init_done && reset_n;
    assign accept_s  = req_valid && req_ready;
    assign rw_ok_s   = (req_rw == RW_READ) || (req_rw == RW_WRITE);

    // Wait lengths derived from the captured request; a zero delay still costs one cycle.
    always_comb begin
        dly_eff_s = (dly_r == 6'd0) ? 8'd1 : {2'b00, dly_r};
        beats_s   = (bl_r == 4'd4) ? 8'd2 : 8'd4;
        recov_s   = (rw_r == RW_WRITE) ? TWR_L : TRTP_L;
    end

    // Next-state logic; each wait state is entered with cnt = remaining cycles in it.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && rw_ok_s) begin
                    state_s = ACT;
                end else if (accept_s) begin
                    err_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACT: begin
                if (TRCD_L <= 8'd1) begin
                    state_s = CAS;
                end else begin
                    state_s = RCD;
                    cnt_s   = TRCD_L - 8'd1;
                end
            end
            CAS: begin
                if (dly_eff_s == 8'd1) begin
                    state_s = BURST;
                    cnt_s   = beats_s;
                end else begin
                    state_s = LAT;
                    cnt_s   = dly_eff_s - 8'd1;
                end
            end
            RCD, LAT, RECOV, RP: begin
                if (cnt_r > 8'd1) begin
                    cnt_s = cnt_r - 8'd1;
                end else begin
                    cnt_s = 8'd0;
                    case (state_r)
                        RCD:     state_s = CAS;
                        LAT:     begin state_s = BURST; cnt_s = beats_s; end
                        RECOV:   state_s = PRE;
                        default: state_s = IDLE;
                    endcase
                end
            end
            BURST: begin
                if (cnt_r > 8'd1) begin
                    cnt_s = cnt_r - 8'd1;
                end else if (recov_s <= 8'd1) begin
                    state_s = PRE;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = RECOV;
                    cnt_s   = recov_s - 8'd1;
                end
            end
            PRE: begin
                if (TRP_L <= 8'd1) begin
                    state_s = IDLE;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = RP;
                    cnt_s   = TRP_L - 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // State, counter, captured request and registered strobes.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            cnt_r         <= 8'd0;
            rw_r          <= 2'b00;
            dly_r         <= 6'd0;
            bl_r          <= 4'd0;
            act_rdy_r     <= 1'b0;
            cas_rdy_r     <= 1'b0;
            rw_rdy_r      <= 1'b0;
            pre_rdy_r     <= 1'b0;
            data_active_r <= 1'b0;
            cmd_err_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s && rw_ok_s) begin
                rw_r  <= req_rw;
                bl_r  <= bl;
                dly_r <= (req_rw == RW_WRITE) ? wr_delay : rd_delay;
            end else begin
                rw_r  <= rw_r;
                bl_r  <= bl_r;
                dly_r <= dly_r;
            end
            act_rdy_r     <= (state_s == ACT);
            cas_rdy_r     <= (state_s == CAS);
            pre_rdy_r     <= (state_s == PRE);
            rw_rdy_r      <= (state_s == BURST) && (state_r != BURST);
            data_active_r <= (state_s == BURST);
            cmd_err_r     <= err_s;
            busy_r        <= (state_s != IDLE);
        end
    end

    assign act_rdy     = act_rdy_r;
    assign cas_rdy     = cas_rdy_r;
    assign rw_rdy      = rw_rdy_r;
    assign pre_rdy     = pre_rdy_r;
    assign data_active = data_active_r;
    assign cmd_err     = cmd_err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer: strobe cycle numbers are counted
// from the accepting clock edge (cycle 0) and compared to hand-derived values.
module tb_ddr_cmd_sequencer;

    logic       clock_t = 1'b0;
    logic       reset_n = 1'b0;
    logic       init_done = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_rw = 2'b00;
    logic       req_ready;
    logic [5:0] rd_delay = 6'd0;
    logic [5:0] wr_delay = 6'd0;
    logic [3:0] bl = 4'd8;
    logic       act_rdy, cas_rdy, rw_rdy, pre_rdy, data_active, cmd_err, busy;

    int n_checks = 0;
    int n_errors = 0;

    int first_act, first_cas, first_rw, first_pre, first_da, last_da, first_rdy, first_err;
    int act_cnt, cas_cnt, rw_cnt, pre_cnt, da_cnt, err_cnt, busy_cnt, rdy_cnt, multi_cnt, busy_at1;

    ddr_cmd_sequencer dut (
        .clock_t     (clock_t),
        .reset_n     (reset_n),
        .init_done   (init_done),
        .req_valid   (req_valid),
        .req_rw      (req_rw),
        .req_ready   (req_ready),
        .rd_delay    (rd_delay),
        .wr_delay    (wr_delay),
        .bl          (bl),
        .act_rdy     (act_rdy),
        .cas_rdy     (cas_rdy),
        .rw_rdy      (rw_rdy),
        .pre_rdy     (pre_rdy),
        .data_active (data_active),
        .cmd_err     (cmd_err),
        .busy        (busy)
    );

    always #5 clock_t = ~clock_t;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Samples ncyc cycles at the falling edge, cycle k being the k-th after the accept edge.
    task automatic observe(input int ncyc);
        first_act = -1; first_cas = -1; first_rw = -1; first_pre = -1;
        first_da = -1; last_da = -1; first_rdy = -1; first_err = -1;
        act_cnt = 0; cas_cnt = 0; rw_cnt = 0; pre_cnt = 0; da_cnt = 0;
        err_cnt = 0; busy_cnt = 0; rdy_cnt = 0; multi_cnt = 0; busy_at1 = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clock_t);
            if (act_rdy) begin act_cnt++; if (first_act < 0) first_act = k; end
            if (cas_rdy) begin cas_cnt++; if (first_cas < 0) first_cas = k; end
            if (rw_rdy)  begin rw_cnt++;  if (first_rw  < 0) first_rw  = k; end
            if (pre_rdy) begin pre_cnt++; if (first_pre < 0) first_pre = k; end
            if (cmd_err) begin err_cnt++; if (first_err < 0) first_err = k; end
            if (data_active) begin da_cnt++; last_da = k; if (first_da < 0) first_da = k; end
            if (req_ready) begin rdy_cnt++; if (first_rdy < 0) first_rdy = k; end
            if (busy) busy_cnt++;
            if (k == 1) busy_at1 = int'(busy);
            if (int'(act_rdy) + int'(cas_rdy) + int'(pre_rdy) > 1) multi_cnt++;
        end
    endtask

    // Presents a request once req_ready is up and returns just after the accepting edge.
    task automatic issue(input logic [1:0] rw, input logic [5:0] rd, input logic [5:0] wr,
                         input logic [3:0] b);
        int waited;
        waited = 0;
        @(negedge clock_t);
        while (!req_ready && waited < 200) begin
            @(negedge clock_t);
            waited++;
        end
        check_eq("ready_before_issue", int'(req_ready), 1);
        req_rw = rw; rd_delay = rd; wr_delay = wr; bl = b; req_valid = 1'b1;
        @(posedge clock_t);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        // Reset state: everything low even with init_done high.
        init_done = 1'b1;
        #12;
        check_eq("reset_outputs",
                 int'({req_ready, act_rdy, cas_rdy, rw_rdy, pre_rdy, data_active, cmd_err, busy}), 0);
        @(negedge clock_t);
        reset_n = 1'b1;
        #1 check_eq("ready_after_reset", int'(req_ready), 1);

        // READ rd_delay=14 bl=8
        issue(2'b01, 6'd14, 6'd3, 4'd8);
        observe(60);
        check_eq("rd_act", first_act, 1);
        check_eq("rd_busy1", busy_at1, 1);
        check_eq("rd_cas", first_cas, 17);
        check_eq("rd_rw", first_rw, 31);
        check_eq("rd_da_first", first_da, 31);
        check_eq("rd_da_last", last_da, 34);
        check_eq("rd_da_cnt", da_cnt, 4);
        check_eq("rd_pre", first_pre, 40);
        check_eq("rd_ready", first_rdy, 56);
        check_eq("rd_strobe_cnt", act_cnt + cas_cnt + rw_cnt + pre_cnt, 4);
        check_eq("rd_multi", multi_cnt, 0);
        check_eq("rd_busy_cnt", busy_cnt, 55);

        // WRITE wr_delay=10 bl=4; inputs disturbed after accept must not matter
        issue(2'b10, 6'd2, 6'd10, 4'd4);
        wr_delay = 6'd3; rd_delay = 6'd40; bl = 4'd8; req_rw = 2'b01;
        observe(60);
        check_eq("wr_act", first_act, 1);
        check_eq("wr_cas", first_cas, 17);
        check_eq("wr_rw", first_rw, 27);
        check_eq("wr_da_first", first_da, 27);
        check_eq("wr_da_cnt", da_cnt, 2);
        check_eq("wr_pre", first_pre, 40);
        check_eq("wr_ready", first_rdy, 56);

        // Invalid request type
        issue(2'b11, 6'd5, 6'd5, 4'd8);
        observe(10);
        check_eq("inv_err", first_err, 1);
        check_eq("inv_err_cnt", err_cnt, 1);
        check_eq("inv_act_cnt", act_cnt, 0);
        check_eq("inv_ready", first_rdy, 1);
        check_eq("inv_busy", busy_cnt, 0);

        // READ with zero delay, bl=4
        issue(2'b01, 6'd0, 6'd9, 4'd4);
        observe(50);
        check_eq("rd0_cas", first_cas, 17);
        check_eq("rd0_rw", first_rw, 18);
        check_eq("rd0_da_cnt", da_cnt, 2);
        check_eq("rd0_pre", first_pre, 25);
        check_eq("rd0_ready", first_rdy, 41);

        // Reset asserted at cycle 20 of a READ
        issue(2'b01, 6'd14, 6'd0, 4'd8);
        repeat (20) @(negedge clock_t);
        reset_n = 1'b0;
        #1 check_eq("rst_mid_outputs",
                    int'({req_ready, act_rdy, cas_rdy, rw_rdy, pre_rdy, data_active, cmd_err, busy}), 0);
        repeat (3) @(negedge clock_t);
        reset_n = 1'b1;
        observe(60);
        check_eq("rst_no_cas", cas_cnt, 0);
        check_eq("rst_no_rw", rw_cnt, 0);
        check_eq("rst_no_strobes", act_cnt + pre_cnt + da_cnt + err_cnt, 0);
        check_eq("rst_ready", first_rdy, 1);

        // init_done low with req_valid held for 50 cycles
        init_done = 1'b0;
        req_rw = 2'b01; rd_delay = 6'd4; bl = 4'd8;
        req_valid = 1'b1;
        observe(50);
        req_valid = 1'b0;
        check_eq("noinit_ready", rdy_cnt, 0);
        check_eq("noinit_strobes", act_cnt + cas_cnt + rw_cnt + pre_cnt + err_cnt + da_cnt, 0);
        check_eq("noinit_busy", busy_cnt, 0);

        // init_done drops right after accept: sequence completes, nothing new accepted
        init_done = 1'b1;
        issue(2'b01, 6'd14, 6'd0, 4'd8);
        init_done = 1'b0;
        req_valid = 1'b1;
        observe(70);
        req_valid = 1'b0;
        check_eq("drop_pre", first_pre, 40);
        check_eq("drop_act_cnt", act_cnt, 1);
        check_eq("drop_ready", rdy_cnt, 0);
        check_eq("drop_busy_end", int'(busy), 0);
        init_done = 1'b1;
        #1 check_eq("drop_ready_back", int'(req_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_sequencer.md
DDR_CMD_SEQUENCER -- requirements
Module: ddr_cmd_sequencer

Interface
REQ-001 SHALL have parameter TRCD, default 16, ACT-to-CAS delay in clock_t cycles (range 1..255).
REQ-002 SHALL have parameter TWR, default 12, last-write-beat-to-PRE delay in cycles (range 1..255).
REQ-003 SHALL have parameter TRTP, default 6, last-read-beat-to-PRE delay in cycles (range 1..255).
REQ-004 SHALL have parameter TRP, default 16, PRE-to-next-accept delay in cycles (range 1..255).
REQ-005 SHALL have port clock_t, input, 1 bit, the only clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port init_done, input, 1 bit, high when the MRS/ZQCL init sequence is complete.
REQ-008 SHALL have port req_valid, input, 1 bit, request present.
REQ-009 SHALL have port req_rw, input, 2 bits, request type: 2'b01 READ, 2'b10 WRITE, other values invalid.
REQ-010 SHALL have port req_ready, output, 1 bit, request accepted when high together with req_valid.
REQ-011 SHALL have port rd_delay, input, 6 bits, CAS-to-read-data delay (RD_DELAY).
REQ-012 SHALL have port wr_delay, input, 6 bits, CAS-to-write-data delay (WR_DELAY).
REQ-013 SHALL have port bl, input, 4 bits, burst length (BL), either 4 or 8.
REQ-014 SHALL have ports act_rdy, cas_rdy, rw_rdy and pre_rdy, each an output of 1 bit, each a single-cycle strobe to the burst/data stage.
REQ-015 SHALL have port data_active, output, 1 bit, high during the DDR data beats.
REQ-016 SHALL have port cmd_err, output, 1 bit, single-cycle strobe flagging an invalid request.
REQ-017 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-018 SHALL implement the states IDLE, ACT, RCD, CAS, LAT, BURST, RECOV, PRE and RP.
REQ-019 SHALL drive req_ready = (state==IDLE) && init_done && reset_n, combinationally.
REQ-020 SHALL accept a request on the edge where req_valid && req_ready, capturing req_rw, bl, and whichever of rd_delay/wr_delay matches req_rw; later changes to these inputs SHALL NOT affect the request in flight.
REQ-021 SHALL, for a valid request accepted at edge N, assert act_rdy only in cycle N+1.
REQ-022 SHALL assert cas_rdy exactly TRCD cycles after the act_rdy cycle.
REQ-023 SHALL assert rw_rdy exactly D cycles after the cas_rdy cycle, where D is the captured delay and a captured value of 0 is treated as 1.
REQ-024 SHALL assert data_active for bl/2 consecutive cycles, starting in the rw_rdy cycle; a captured bl other than 4 SHALL be treated as 8.
REQ-025 SHALL assert pre_rdy exactly TWR (WRITE) or TRTP (READ) cycles after the last data_active cycle.
REQ-026 SHALL return to IDLE so that req_ready is high exactly TRP cycles after the pre_rdy cycle.
REQ-027 SHALL, for an invalid req_rw, still accept the request but assert only cmd_err in cycle N+1, issue no commands, and have req_ready high again in cycle N+1.
REQ-028 SHALL assert at most one of act_rdy/cas_rdy/pre_rdy in any cycle.
REQ-029 SHALL allow only one request in flight; req_valid outside IDLE SHALL be ignored.
REQ-030 SHALL, if init_done falls mid-sequence, complete the current sequence and accept nothing further until init_done rises.
REQ-031 SHALL hold all delay counters at 8 bits with no wrap-around.

Reset
REQ-032 SHALL, while reset_n is low, force state=IDLE, all counters=0, and all outputs (including req_ready and busy) to 0, asynchronously.
REQ-033 SHALL, when reset is asserted mid-sequence, abort the sequence with no trailing strobe after release.

Verification
REQ-034 SHALL verify a READ with rd_delay=14 and bl=8 accepted at cycle 0 -> act_rdy@1, cas_rdy@17, rw_rdy@31, data_active@31-34, pre_rdy@40, req_ready@56.
REQ-035 SHALL verify a WRITE with wr_delay=10 and bl=4 accepted at cycle 0 -> act_rdy@1, cas_rdy@17, rw_rdy@27, data_active@27-28, pre_rdy@40, req_ready@56.
REQ-036 SHALL verify req_rw=2'b11 accepted at cycle 0 -> cmd_err@1, no act_rdy, req_ready@1.
REQ-037 SHALL verify a READ with rd_delay=0 -> rw_rdy one cycle after cas_rdy.
REQ-038 SHALL verify reset_n low at cycle 20 of a READ -> all outputs 0 immediately, no cas_rdy/rw_rdy after release, and req_ready high once reset_n and init_done are both high.
REQ-039 SHALL verify init_done=0 with req_valid held high for 50 cycles -> req_ready=0, no strobes, busy=0.
